// File: rtl/decode_stage.sv
// Instruction decode stage: decodes a small RV32 subset on push and buffers the
// results in a 2-entry FIFO, with saturating decoded/illegal statistics counters.
module decode_stage #(
    parameter int INSTR_WIDTH = 32,
    parameter int C_SIG_WIDTH = 7,
    parameter int PC_WIDTH    = 32,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_WIDTH-1:0] in_instr,
    input  logic [PC_WIDTH-1:0]    in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [C_SIG_WIDTH-1:0] out_ctrl,
    output logic [4:0]             out_rd,
    output logic [4:0]             out_rs1,
    output logic [4:0]             out_rs2,
    output logic [31:0]            out_imm,
    output logic [PC_WIDTH-1:0]    out_pc,
    output logic                   out_illegal,
    output logic [CNT_WIDTH-1:0]   decoded_cnt,
    output logic [CNT_WIDTH-1:0]   illegal_cnt
);

    typedef struct packed {
        logic [6:0]          ctrl;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [31:0]         imm;
        logic [PC_WIDTH-1:0] pc;
        logic                illegal;
    } entry_t;

    entry_t     mem [2];
    entry_t     dec;
    entry_t     head;
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;
    logic [6:0] opcode;
    logic [2:0] funct3;

    // Handshake: a beat transfers on an edge where valid & ready are both high.
    // Once valid is raised the sender holds its payload until that edge; in_ready
    // comes only from the registered occupancy, never from out_ready.
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];

    always_comb begin
        dec         = '0;
        dec.rd      = in_instr[11:7];
        dec.rs1     = in_instr[19:15];
        dec.rs2     = in_instr[24:20];
        dec.pc      = in_pc;
        dec.illegal = 1'b1;
        case (opcode)
            7'b0110011: begin
                dec.ctrl    = 7'b1000000;
                dec.illegal = 1'b0;
            end
            7'b0010011: begin
                dec.ctrl    = 7'b1100000;
                dec.imm     = {{20{in_instr[31]}}, in_instr[31:20]};
                dec.illegal = 1'b0;
            end
            7'b0000011: begin
                if (funct3 == 3'b000 || funct3 == 3'b010) begin
                    dec.ctrl    = (funct3 == 3'b000) ? 7'b1101011 : 7'b1101010;
                    dec.imm     = {{20{in_instr[31]}}, in_instr[31:20]};
                    dec.illegal = 1'b0;
                end
            end
            7'b0100011: begin
                if (funct3 == 3'b000 || funct3 == 3'b010) begin
                    dec.ctrl    = (funct3 == 3'b000) ? 7'b0100101 : 7'b0100100;
                    dec.imm     = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                    dec.illegal = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Flush takes priority over push/pop; counters only advance on real pushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0]      <= '0;
            mem[1]      <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            decoded_cnt <= '0;
            illegal_cnt <= '0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= dec;
                wr_ptr      <= ~wr_ptr;
                if (decoded_cnt != '1)
                    decoded_cnt <= decoded_cnt + CNT_WIDTH'(1);
                if (dec.illegal && illegal_cnt != '1)
                    illegal_cnt <= illegal_cnt + CNT_WIDTH'(1);
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Storage is cleared by reset, so the head reads as all zeros during reset.
    assign head        = mem[rd_ptr];
    assign out_ctrl    = C_SIG_WIDTH'(head.ctrl);
    assign out_rd      = head.rd;
    assign out_rs1     = head.rs1;
    assign out_rs2     = head.rs2;
    assign out_imm     = head.imm;
    assign out_pc      = head.pc;
    assign out_illegal = head.illegal;

endmodule
